// File: rtl/hamming_dec_arb.sv
// hamming_dec_arb
// Two-requester round-robin front end feeding a Hamming(7,4) single-error
// corrector. One word is in flight at a time and moves through a fixed
// four-state pipeline: accept, syndrome, correct, present.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   req0_valid/code/ready      requester 0 handshake + 7-bit codeword
//   req1_valid/code/ready      requester 1 handshake + 7-bit codeword
//   out_valid/out_ready        result handshake
//   out_code, out_data         corrected codeword and its 4 data bits
//   out_id, out_err            source requester, nonzero-syndrome flag
//   clr_cnt, err_cnt           clear / saturating corrected-word counter
//
// state | meaning
// IDLE  | waiting for a transfer; the only state where ready can be high
// SYND  | syndrome of the captured word is registered
// CORR  | corrected word, data and error flag are registered
// OUT   | result presented until out_ready

module hamming_dec_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [6:0]       req0_code,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [6:0]       req1_code,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic [3:0]       out_data,
  output logic             out_id,
  output logic             out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, SYND, CORR, OUT} state_t;

  state_t           state_q, state_d;
  logic [6:0]       code_q, code_d;
  logic             id_q, id_d;
  logic [2:0]       synd_q, synd_d;
  logic             last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [6:0]       out_code_q, out_code_d;
  logic [3:0]       out_data_q, out_data_d;
  logic             out_id_q, out_id_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic grant0, grant1, xfer0, xfer1, out_hs;
  logic [6:0] flip, corrected;
  logic [2:0] synd_calc;

  // On a tie the requester that did not win last time goes; last_q resets
  // to 1 so requester 0 wins the first tie.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  // rst_n gating keeps ready low while reset holds the FSM in IDLE.
  assign req0_ready = rst_n && (state_q == IDLE) && grant0;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign out_hs     = out_valid_q && out_ready;

  assign synd_calc = {^{code_q[3], code_q[4], code_q[5], code_q[6]},
                      ^{code_q[1], code_q[2], code_q[5], code_q[6]},
                      ^{code_q[0], code_q[2], code_q[4], code_q[6]}};

  // Syndrome s names Hamming position s, i.e. bit s-1; zero selects no bit.
  always_comb begin
    flip = '0;
    for (int i = 0; i < 7; i++) begin
      flip[i] = (synd_q == 3'(i + 1));
    end
  end

  assign corrected = code_q ^ flip;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    id_d        = id_q;
    synd_d      = synd_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (xfer0 || xfer1) begin
          code_d  = xfer1 ? req1_code : req0_code;
          id_d    = xfer1;
          last_d  = xfer1;
          state_d = SYND;
        end
      end
      SYND: begin
        synd_d  = synd_calc;
        state_d = CORR;
      end
      CORR: begin
        out_code_d  = corrected;
        out_data_d  = {corrected[6], corrected[5], corrected[4], corrected[2]};
        out_err_d   = |synd_q;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear takes priority over a coincident counting handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (out_hs && out_err_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      code_q      <= '0;
      id_q        <= 1'b0;
      synd_q      <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      out_data_q  <= '0;
      out_id_q    <= 1'b0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      id_q        <= id_d;
      synd_q      <= synd_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_err   = out_err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_hamming_dec_arb.sv
// Directed bench for hamming_dec_arb, built with a 2-bit error counter so
// saturation is reachable in a few words.

module tb_hamming_dec_arb;

  logic       clk, rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [6:0] req0_code, req1_code;
  logic       out_valid, out_ready, out_id, out_err, clr_cnt;
  logic [6:0] out_code;
  logic [3:0] out_data;
  logic [1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  hamming_dec_arb #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_code  (req0_code),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_code  (req1_code),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_err    (out_err),
    .clr_cnt    (clr_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clr_cnt    = 1'b0;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  // Returns just after the transfer edge (edge N).
  task automatic offer(input bit id, input logic [6:0] code);
    int n;
    n = 0;
    if (id) begin req1_valid = 1'b1; req1_code = code; end
    else    begin req0_valid = 1'b1; req0_code = code; end
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    check("grant_timeout", 32'(n < 20), 32'd1);
    tick();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic run_word(input bit id, input logic [6:0] code, input logic [6:0] e_code,
                          input logic [3:0] e_data, input bit e_err, input logic [1:0] e_cnt);
    offer(id, code);
    check("lat_n0", 32'(out_valid), 32'd0);
    tick();
    check("lat_n1", 32'(out_valid), 32'd0);
    tick();
    check("lat_n2", 32'(out_valid), 32'd1);
    check("out_code", 32'(out_code), 32'(e_code));
    check("out_data", 32'(out_data), 32'(e_data));
    check("out_err", 32'(out_err), 32'(e_err));
    check("out_id", 32'(out_id), 32'(id));
    tick();
    check("hs_done", 32'(out_valid), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'(e_cnt));
  endtask

  initial begin
    int gcount, last_g;
    bit seen;
    rst_n = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_code = 7'b0; req1_code = 7'b0;
    #2;
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_code", 32'(out_code), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_err", 32'(out_err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;

    run_word(1'b0, 7'b1101100, 7'b1001100, 4'b1001, 1'b1, 2'd1);
    run_word(1'b1, 7'b0101100, 7'b0101101, 4'b0101, 1'b1, 2'd2);
    run_word(1'b0, 7'b1001100, 7'b1001100, 4'b1001, 1'b0, 2'd2);

    // Stall in OUT for 5 cycles with requester 0 waiting.
    out_ready = 1'b0;
    offer(1'b1, 7'b0101100);
    tick();
    tick();
    req0_valid = 1'b1; req0_code = 7'b1101100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_code", 32'(out_code), 32'h2D);
      check("stall_ready", 32'(req0_ready), 32'd0);
    end
    req0_valid = 1'b0;
    out_ready  = 1'b1;
    tick();
    check("stall_release", 32'(out_valid), 32'd0);
    check("stall_cnt", 32'(err_cnt), 32'd3);

    // Saturation from a clean counter.
    do_reset();
    run_word(1'b0, 7'b1101100, 7'b1001100, 4'b1001, 1'b1, 2'd1);
    run_word(1'b1, 7'b0101100, 7'b0101101, 4'b0101, 1'b1, 2'd2);
    run_word(1'b0, 7'b1101100, 7'b1001100, 4'b1001, 1'b1, 2'd3);
    run_word(1'b1, 7'b0101100, 7'b0101101, 4'b0101, 1'b1, 2'd3);

    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_alone", 32'(err_cnt), 32'd0);

    // Clear coincident with a counting handshake.
    offer(1'b0, 7'b1101100);
    tick();
    tick();
    check("clr_hs_valid", 32'(out_valid), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_hs_done", 32'(out_valid), 32'd0);
    check("clr_wins", 32'(err_cnt), 32'd0);

    // Round robin with both requesters permanently valid.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_code = 7'b1001100;
    req1_valid = 1'b1; req1_code = 7'b0101100;
    tick();
    rst_n = 1'b1;
    #1;
    gcount = 0;
    last_g = 0;
    for (int cyc = 0; cyc < 17; cyc++) begin
      if (req0_ready && req1_ready) check("rr_both_ready", 32'd1, 32'd0);
      if (out_valid) check("rr_ready_busy", 32'(req0_ready | req1_ready), 32'd0);
      if (req0_ready || req1_ready) begin
        check("rr_grant_id", 32'(req1_ready), 32'(gcount % 2));
        check("rr_spacing", 32'(cyc), 32'(4 * gcount));
        gcount++;
      end
      tick();
    end
    check("rr_count", 32'(gcount), 32'd5);

    // Reset while the word sits in SYND.
    do_reset();
    offer(1'b0, 7'b1101100);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(req0_ready), 32'd0);
    tick();
    check("midrst_hold_ready", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_out", 32'(seen), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("resume_tie0", 32'(req0_ready), 32'd1);
    check("resume_tie1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
